rtc_burst_engine: RTL and testbench
===================================

# rtc_burst_engine

Parametrised serial master for a DS1302-style three-wire RTC (CE, SCLK, bidirectional I/O). It runs complete burst transactions: one command byte followed by NUM_BYTES data bytes, either written from a parallel load bus or read into a parallel capture bus. The SCLK rate is set by a clock divider. It sits between the RTC controller FSM and the pads, and generalises the fixed-sequence write-only burst writer.

## Interface
- CLK_DIV, 2: clk cycles per SCLK half-period, legal range 1..255.
- NUM_BYTES, 8: data bytes per burst, legal range 1..31.
- clk  in  1  system clock; all logic on its rising edge.
- rstn  in  1  reset: one clock, synchronous, active-low.
- start  in  1  transaction request, sampled only in IDLE.
- rw  in  1  transaction direction: 1 = read, 0 = write. Sampled with start.
- cmd_byte  in  8  command/address byte. Bit0 is overridden by rw and bit7 is forced to 1 on the wire.
- wr_data  in  8*NUM_BYTES  write payload. Byte k is wr_data[8k+7:8k]. Sampled with start.
- rd_data  out  8*NUM_BYTES  read payload, same byte mapping as wr_data.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- ce  out  1  RTC chip enable.
- sclk  out  1  RTC serial clock.
- io_out  out  1  serial data to the pad.
- io_oe  out  1  pad output enable.
- io_in  in  1  serial data from the pad.

## Operation
- States: IDLE, CMD, DATA, HOLD.
- Reset (rstn=0 at a clk edge) forces the following on that edge:
  - state=IDLE.
  - busy=0, done=0, ce=0, sclk=0, io_out=0.
  - io_oe=1.
  - rd_data=0, all counters 0.
- Reset applies mid-transaction too: the burst is aborted and no done pulse is issued.
- IDLE, start=1: latch the following, then go to CMD.
  - Shift register ← {1, cmd_byte[6:1], rw}.
  - Payload ← wr_data.
  - Direction ← rw.
- Bit cell: 2*CLK_DIV cycles.
  - First CLK_DIV cycles: sclk=0. io_out presents the new bit from the first cycle of the low phase.
  - Next CLK_DIV cycles: sclk=1.
  - Bits go out LSB first.
- CMD: 8 bit cells, io_oe=1. After the 8th cell:
  - write → DATA with io_oe=1;
  - read → DATA with io_oe=0, io_out=0.
- DATA: 8*NUM_BYTES bit cells, byte 0 first, LSB first.
  - Write: the payload is shifted out.
  - Read: io_in is sampled on the last clk cycle of each high phase and shifted into byte 0 bit 0 upward. rd_data is updated only at the end of DATA (no partial values are visible).
- HOLD: CLK_DIV cycles with sclk=0, ce=1 and io_oe=1 (io_out=0). Then return to IDLE.
- busy=1 and ce=1 in CMD, DATA and HOLD.
- done=1 for the single cycle after HOLD ends; in that cycle state=IDLE, ce=0 and busy=0.
- start while busy: ignored, not queued.
- start asserted in the done cycle: accepted, since the state is IDLE.
- rd_data holds its value until the next read transaction completes. Write transactions leave rd_data unchanged.
- Internal counters: the half-period counter is 8 bits and the bit counter is 9 bits (maximum 8+248=256 bits). Both wrap to 0 at the end of each cell or phase; no overflow is possible within the legal ranges.

## Timing
- start sampled at edge T → ce=1, busy=1 from T+1.
- First sclk rise at T+1+CLK_DIV.
- ce-high duration: (8 + 8*NUM_BYTES) * 2*CLK_DIV + CLK_DIV cycles. For the defaults: 72*4 + 2 = 290.
- done asserted at T+1+290 for the defaults.
- io_out changes only while sclk=0, at least CLK_DIV cycles before the next rise. It is stable through the whole high phase.
- Back-to-back transactions: minimum ce-low gap is 1 cycle (start held high through the done cycle).

## Configuration
- RTC_BURST_READ_EN defined:
  - read transactions are supported as described above.
- RTC_BURST_READ_EN undefined:
  - the read path is removed;
  - rw is ignored and cmd bit0 is sent as 0;
  - io_oe is constant 1;
  - rd_data is tied to 0;
  - io_in is unused.
- The write path and all timing are identical in both builds.

## Test plan
- Reset: defaults, rstn=0 for 2 cycles mid-burst → next edge gives ce=0, sclk=0, busy=0, io_oe=1, rd_data=0, and no done pulse.
- Write burst: defaults, cmd_byte=0xBE, rw=0, wr_data byte0=0x52, byte1=0x43, others 0x00.
  - The bits captured on sclk rises read 0xBE, 0x52, 0x43, then 0x00 ×6.
  - ce is high for exactly 290 cycles.
  - done pulses once.
- Read burst (RTC_BURST_READ_EN): cmd_byte=0xBF, rw=1, with a device model driving 0x59, 0x30, 0x12, 0x01…
  - io_oe falls after the 8th command cell.
  - rd_data[31:0]=0x01123059 at done.
  - rd_data is unchanged during DATA.
- Divider edge: CLK_DIV=1, NUM_BYTES=1, cmd_byte=0x80, wr_data=0xA5.
  - sclk toggles every cycle.
  - ce is high for 33 cycles.
  - The wire bits are 0x80, then 0xA5.
- Handshake:
  - start pulsed every cycle during a burst → exactly one transaction.
  - start held high through the done cycle → second ce rise exactly 1 cycle after ce falls.
  - cmd_byte=0x00 → 0x80 sent.
- Build without RTC_BURST_READ_EN, rw=1:
  - a write is performed with bit0 sent as 0;
  - io_oe stays 1 throughout;
  - rd_data stays 0.

Source files
------------

// File: rtl/rtc_burst_engine.sv
// Burst serial master for a DS1302-style three-wire RTC: command byte plus NUM_BYTES data bytes.
// Define RTC_BURST_READ_EN to include the read path; without it only write bursts are performed.
module rtc_burst_engine #(
  parameter int CLK_DIV   = 2,
  parameter int NUM_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   rw,
  input  logic [7:0]             cmd_byte,
  input  logic [8*NUM_BYTES-1:0] wr_data,
  output logic [8*NUM_BYTES-1:0] rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   ce,
  output logic                   sclk,
  output logic                   io_out,
  output logic                   io_oe,
  input  logic                   io_in
);

  localparam int DW = 8 * NUM_BYTES;
  localparam int SW = DW + 8;
  localparam logic [7:0] HC_LAST   = 8'(CLK_DIV - 1);
  localparam logic [8:0] CMD_LAST  = 9'd7;
  localparam logic [8:0] DATA_LAST = 9'(DW - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

  state_t        state, state_nxt;
  logic [7:0]    hcnt;
  logic          phase;
  logic [8:0]    bcnt;
  logic [SW-1:0] sr;
  logic          dir;
  logic          rw_eff;
  logic          phase_end;
  logic          cell_end;
  logic          unused_cmd_bits;

  // Bit 7 is always sent as 1 and bit 0 carries the direction.
  assign unused_cmd_bits = ^{cmd_byte[7], cmd_byte[0]};
  assign phase_end = (hcnt == HC_LAST);
  assign cell_end  = phase_end && phase;

`ifdef RTC_BURST_READ_EN
  logic [DW-1:0] rx_sr;

  assign rw_eff = rw;

  // Capture on the last high-phase cycle; rd_data only moves once the whole payload is in.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_sr   <= '0;
      rd_data <= '0;
    end else if (state == DATA && dir && cell_end) begin
      rx_sr <= {io_in, rx_sr[DW-1:1]};
      if (bcnt == DATA_LAST) rd_data <= {io_in, rx_sr[DW-1:1]};
    end
  end
`else
  logic unused_read_inputs;

  assign rw_eff             = 1'b0;
  assign rd_data            = '0;
  assign unused_read_inputs = ^{io_in, rw};
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ce        = 1'b0;
    sclk      = 1'b0;
    io_out    = 1'b0;
    io_oe     = 1'b1;
    case (state)
      IDLE: if (start) state_nxt = CMD;
      CMD: begin
        busy   = 1'b1;
        ce     = 1'b1;
        sclk   = phase;
        io_out = sr[0];
        if (cell_end && bcnt == CMD_LAST) state_nxt = DATA;
      end
      DATA: begin
        busy   = 1'b1;
        ce     = 1'b1;
        sclk   = phase;
        io_out = dir ? 1'b0 : sr[0];
        io_oe  = ~dir;
        if (cell_end && bcnt == DATA_LAST) state_nxt = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        ce   = 1'b1;
        if (phase_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      hcnt  <= '0;
      phase <= 1'b0;
      bcnt  <= '0;
      sr    <= '0;
      dir   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == HOLD) && phase_end;
      case (state)
        IDLE: begin
          hcnt  <= '0;
          phase <= 1'b0;
          bcnt  <= '0;
          if (start) begin
            sr  <= {wr_data, 1'b1, cmd_byte[6:1], rw_eff};
            dir <= rw_eff;
          end
        end
        CMD, DATA: begin
          if (phase_end) begin
            hcnt  <= '0;
            phase <= ~phase;
          end else begin
            hcnt <= hcnt + 8'd1;
          end
          // Shifting at cell end puts the next bit on io_out from the first low cycle.
          if (cell_end) begin
            sr <= sr >> 1;
            if ((state == CMD && bcnt == CMD_LAST) || (state == DATA && bcnt == DATA_LAST))
              bcnt <= '0;
            else
              bcnt <= bcnt + 9'd1;
          end
        end
        HOLD: begin
          if (phase_end) hcnt <= '0;
          else           hcnt <= hcnt + 8'd1;
        end
        default: hcnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_burst_engine.sv
// Directed bench for rtc_burst_engine: default instance (2/8) and a CLK_DIV=1, NUM_BYTES=1 instance.
module tb_rtc_burst_engine;

`ifdef RTC_BURST_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        start_a = 1'b0, rw_a = 1'b0, io_in_a = 1'b0;
  logic [7:0]  cmd_a = 8'h00;
  logic [63:0] wd_a = '0, rd_a;
  logic        busy_a, done_a, ce_a, sclk_a, io_out_a, io_oe_a;

  logic        start_b = 1'b0, rw_b = 1'b0, io_in_b = 1'b0;
  logic [7:0]  cmd_b = 8'h00, wd_b = 8'h00, rd_b;
  logic        busy_b, done_b, ce_b, sclk_b, io_out_b, io_oe_b;

  logic [71:0] cap;
  logic [63:0] rd_at_done, rd_snap;
  int          ce_len, done_cnt, first_rise, done_cyc, oe_fall_at;
  logic        rd_changed;

  always #5 clk = ~clk;

  rtc_burst_engine #(.CLK_DIV(2), .NUM_BYTES(8)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .rw(rw_a), .cmd_byte(cmd_a),
    .wr_data(wd_a), .rd_data(rd_a), .busy(busy_a), .done(done_a), .ce(ce_a),
    .sclk(sclk_a), .io_out(io_out_a), .io_oe(io_oe_a), .io_in(io_in_a)
  );

  rtc_burst_engine #(.CLK_DIV(1), .NUM_BYTES(1)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .rw(rw_b), .cmd_byte(cmd_b),
    .wr_data(wd_b), .rd_data(rd_b), .busy(busy_b), .done(done_b), .ce(ce_b),
    .sclk(sclk_b), .io_out(io_out_b), .io_oe(io_oe_b), .io_in(io_in_b)
  );

  // One full burst on dut_a; a device model drives dev bits on io_in during DATA.
  task automatic run_a(input logic [7:0] cmd, input logic rwv, input logic [63:0] wd,
                       input logic [63:0] dev);
    int   nrise;
    logic prev_sclk;
    @(negedge clk);
    start_a = 1'b1; cmd_a = cmd; rw_a = rwv; wd_a = wd;
    @(negedge clk);
    start_a = 1'b0;
    cap = '0; nrise = 0; ce_len = 0; done_cnt = 0; first_rise = -1; done_cyc = -1;
    oe_fall_at = -1; rd_changed = 1'b0; prev_sclk = 1'b0; rd_snap = rd_a; rd_at_done = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (ce_a) ce_len++;
      if (done_a) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        rd_at_done = rd_a;
      end
      if (sclk_a && !prev_sclk) begin
        if (first_rise < 0) first_rise = cyc;
        if (nrise < 72) cap[nrise] = io_out_a;
        if (nrise >= 8 && nrise < 72) io_in_a = dev[nrise-8];
        nrise++;
      end
      if (!io_oe_a && oe_fall_at < 0) oe_fall_at = nrise;
      if (rd_a !== rd_snap && (nrise < 72 || sclk_a)) rd_changed = 1'b1;
      prev_sclk = sclk_a;
      @(negedge clk);
    end
    io_in_a = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (ce_a !== 1'b0)    begin errors++; $display("FAIL reset_ce got %b exp 0", ce_a); end
    checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    checks++; if (sclk_a !== 1'b0)  begin errors++; $display("FAIL reset_sclk got %b exp 0", sclk_a); end
    checks++; if (io_out_a !== 1'b0) begin errors++; $display("FAIL reset_io_out got %b exp 0", io_out_a); end
    checks++; if (io_oe_a !== 1'b1) begin errors++; $display("FAIL reset_io_oe got %b exp 1", io_oe_a); end
    checks++; if (rd_a !== 64'h0)   begin errors++; $display("FAIL reset_rd got %h exp 0", rd_a); end
    checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done_a); end
  endtask

  task automatic test_write;
    run_a(8'hBE, 1'b0, 64'h0000_0000_0000_4352, 64'h0);
    checks++; if (cap !== 72'h00_0000_0000_0000_4352_BE) begin errors++; $display("FAIL write_bits got %h exp %h", cap, 72'h00_0000_0000_0000_4352_BE); end
    checks++; if (ce_len != 290)   begin errors++; $display("FAIL write_ce_len got %0d exp 290", ce_len); end
    checks++; if (done_cnt != 1)   begin errors++; $display("FAIL write_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (first_rise != 2) begin errors++; $display("FAIL write_first_rise got %0d exp 2", first_rise); end
    checks++; if (done_cyc != 290) begin errors++; $display("FAIL write_done_cyc got %0d exp 290", done_cyc); end
    checks++; if (oe_fall_at != -1) begin errors++; $display("FAIL write_io_oe fell at bit %0d exp never", oe_fall_at); end
    checks++; if (rd_a !== 64'h0)  begin errors++; $display("FAIL write_rd got %h exp 0", rd_a); end
  endtask

  task automatic test_read;
    run_a(8'hBF, 1'b1, 64'h0, 64'h0000_0000_0112_3059);
    if (READ_EN) begin
      checks++; if (cap[7:0] !== 8'hBF) begin errors++; $display("FAIL read_cmd got %h exp bf", cap[7:0]); end
      checks++; if (oe_fall_at != 8)    begin errors++; $display("FAIL read_oe_fall got %0d exp 8", oe_fall_at); end
      checks++; if (rd_at_done[31:0] !== 32'h0112_3059) begin errors++; $display("FAIL read_rd got %h exp 01123059", rd_at_done[31:0]); end
      checks++; if (rd_at_done !== 64'h0000_0000_0112_3059) begin errors++; $display("FAIL read_rd_full got %h", rd_at_done); end
      checks++; if (rd_changed !== 1'b0) begin errors++; $display("FAIL read_rd_stable got changed exp stable"); end
      checks++; if (cap[71:8] !== 64'h0) begin errors++; $display("FAIL read_io_out got %h exp 0", cap[71:8]); end
    end else begin
      checks++; if (cap[7:0] !== 8'hBE) begin errors++; $display("FAIL noread_cmd got %h exp be", cap[7:0]); end
      checks++; if (oe_fall_at != -1)   begin errors++; $display("FAIL noread_io_oe fell at bit %0d exp never", oe_fall_at); end
      checks++; if (rd_at_done !== 64'h0) begin errors++; $display("FAIL noread_rd got %h exp 0", rd_at_done); end
    end
    checks++; if (ce_len != 290) begin errors++; $display("FAIL read_ce_len got %0d exp 290", ce_len); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL read_done_cnt got %0d exp 1", done_cnt); end
  endtask

  task automatic test_cmd_zero;
    logic [63:0] rd_exp;
    rd_exp = READ_EN ? 64'h0000_0000_0112_3059 : 64'h0;
    run_a(8'h00, 1'b0, 64'h8877_6655_4433_2211, 64'h0);
    checks++; if (cap !== 72'h88_7766_5544_3322_1180) begin errors++; $display("FAIL cmd_zero_bits got %h exp 8877665544332211 80", cap); end
    checks++; if (rd_a !== rd_exp) begin errors++; $display("FAIL write_keeps_rd got %h exp %h", rd_a, rd_exp); end
  endtask

  task automatic test_reset_mid;
    int dcnt, celen;
    @(negedge clk);
    start_a = 1'b1; rw_a = 1'b1; cmd_a = 8'hBF;
    @(negedge clk);
    start_a = 1'b0;
    repeat (100) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (ce_a !== 1'b0)    begin errors++; $display("FAIL mid_reset_ce got %b exp 0", ce_a); end
    checks++; if (sclk_a !== 1'b0)  begin errors++; $display("FAIL mid_reset_sclk got %b exp 0", sclk_a); end
    checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL mid_reset_busy got %b exp 0", busy_a); end
    checks++; if (io_oe_a !== 1'b1) begin errors++; $display("FAIL mid_reset_io_oe got %b exp 1", io_oe_a); end
    checks++; if (rd_a !== 64'h0)   begin errors++; $display("FAIL mid_reset_rd got %h exp 0", rd_a); end
    @(negedge clk);
    rstn = 1'b1;
    dcnt = 0; celen = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_a) dcnt++;
      if (ce_a) celen++;
      @(negedge clk);
    end
    checks++; if (dcnt != 0)  begin errors++; $display("FAIL mid_reset_done got %0d pulses exp 0", dcnt); end
    checks++; if (celen != 0) begin errors++; $display("FAIL mid_reset_ce_idle got %0d cycles exp 0", celen); end
  endtask

  task automatic test_divider;
    int   nrise, celen;
    logic prev_sclk, toggle_ok;
    logic [15:0] bits;
    @(negedge clk);
    start_b = 1'b1; cmd_b = 8'h80; wd_b = 8'hA5; rw_b = 1'b0;
    @(negedge clk);
    start_b = 1'b0;
    nrise = 0; celen = 0; prev_sclk = 1'b0; toggle_ok = 1'b1; bits = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (ce_b) celen++;
      if (cyc < 32 && sclk_b !== cyc[0]) toggle_ok = 1'b0;
      if (sclk_b && !prev_sclk) begin
        if (nrise < 16) bits[nrise] = io_out_b;
        nrise++;
      end
      prev_sclk = sclk_b;
      @(negedge clk);
    end
    checks++; if (toggle_ok !== 1'b1) begin errors++; $display("FAIL div_sclk_toggle got irregular exp every cycle"); end
    checks++; if (celen != 33)        begin errors++; $display("FAIL div_ce_len got %0d exp 33", celen); end
    checks++; if (bits !== 16'hA580)  begin errors++; $display("FAIL div_bits got %h exp a580", bits); end
    checks++; if (nrise != 16)        begin errors++; $display("FAIL div_rises got %0d exp 16", nrise); end
  endtask

  task automatic test_start_pulsed;
    int   rises;
    logic prev_ce;
    rises = 0; prev_ce = 1'b0;
    cmd_a = 8'h8A; rw_a = 1'b0; wd_a = 64'h0;
    for (int i = 0; i < 350; i++) begin
      @(negedge clk);
      if (ce_a && !prev_ce) rises++;
      prev_ce = ce_a;
      start_a = (i < 250) ? ~start_a : 1'b0;
    end
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rises != 1) begin errors++; $display("FAIL pulsed_start got %0d bursts exp 1", rises); end
  endtask

  task automatic test_back_to_back;
    int   rises, fall_i, rise2_i, done_i;
    logic prev_ce;
    rises = 0; fall_i = -1; rise2_i = -1; done_i = -1; prev_ce = 1'b0;
    @(negedge clk);
    cmd_a = 8'h8A; rw_a = 1'b0; wd_a = 64'h0; start_a = 1'b1;
    for (int i = 0; i < 650; i++) begin
      @(negedge clk);
      if (ce_a && !prev_ce) begin
        rises++;
        if (rises == 2) begin
          rise2_i = i;
          start_a = 1'b0;
        end
      end
      if (!ce_a && prev_ce && fall_i < 0) fall_i = i;
      if (done_a && done_i < 0) done_i = i;
      prev_ce = ce_a;
    end
    start_a = 1'b0;
    checks++; if (rises != 2) begin errors++; $display("FAIL b2b_bursts got %0d exp 2", rises); end
    checks++; if (rise2_i - fall_i != 1) begin errors++; $display("FAIL b2b_gap got %0d exp 1", rise2_i - fall_i); end
    checks++; if (done_i != fall_i) begin errors++; $display("FAIL b2b_done_cycle got %0d exp %0d", done_i, fall_i); end
  endtask

  initial begin
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rstn = 1'b1;
    test_write;
    test_read;
    test_cmd_zero;
    test_reset_mid;
    test_divider;
    test_start_pulsed;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
